nb_symbol_dedup_filter: RTL and testbench

Streaming duplicate-symbol filter for the non-binary LDPC check-node candidate path. Consumes one (GF symbol Q, LLR) candidate per handshake, keeps a table of up to DEPTH distinct symbols per candidate list, and forwards only first occurrences. Duplicates and beyond-capacity candidates are dropped. Sits between the candidate sorter and the check-node output stage, replacing the single-pair Q compare with a registered, multi-entry, list-framed filter.

---
 rtl/nb_symbol_dedup_filter.sv | 193 +++++++++++++++++++
 tb/tb_nb_symbol_dedup_filter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nb_symbol_dedup_filter.sv
// Streaming duplicate-symbol filter for the NB-LDPC check-node candidate path.
// Keeps up to DEPTH distinct GF symbols per candidate list and forwards only
// the first occurrence of each one, tagged with its table slot.
module nb_symbol_dedup_filter #(
  parameter int unsigned Q_WIDTH       = 6,
  parameter int unsigned LLR_WIDTH     = 5,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [Q_WIDTH:0]         in_q,
  input  logic [LLR_WIDTH:0]       in_llr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Q_WIDTH:0]         out_q,
  output logic [LLR_WIDTH:0]       out_llr,
  output logic [COUNTER_WIDTH-1:0] out_idx,
  output logic                     list_done,
  output logic [COUNTER_WIDTH:0]   list_count,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int unsigned CntW = COUNTER_WIDTH + 1;
  localparam logic [COUNTER_WIDTH:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StCollect, StSaturated} state_e;

  state_e state_q, state_d;

  // Symbol table and fill counter
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [Q_WIDTH:0]       tbl_sym_q [DEPTH];
  logic [COUNTER_WIDTH:0] cnt_q, cnt_d;

  // Output and status registers
  logic                     out_valid_q, out_valid_d;
  logic [Q_WIDTH:0]         out_q_q, out_q_d;
  logic [LLR_WIDTH:0]       out_llr_q, out_llr_d;
  logic [COUNTER_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                     list_done_q, list_done_d;
  logic [COUNTER_WIDTH:0]   list_count_q, list_count_d;
  logic                     overflow_q, overflow_d;
  logic                     frame_err_q, frame_err_d;

  // Per-beat decode
  logic                     in_idle;
  logic                     accept;
  logic                     active;
  logic                     match;
  logic                     full;
  logic                     write;
  logic [DEPTH-1:0]         eff_vld;
  logic [DEPTH-1:0]         hit;
  logic [COUNTER_WIDTH:0]   eff_cnt;
  logic [COUNTER_WIDTH-1:0] wr_idx;

  // Parallel compare against the table; in_first masks the old contents.
  always_comb begin
    eff_vld = in_first ? '0 : vld_q;
    eff_cnt = in_first ? '0 : cnt_q;
    hit     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit[i] = eff_vld[i] & (tbl_sym_q[i] == in_q);
    end
    match  = |hit;
    full   = (eff_cnt == FullCnt);
    wr_idx = eff_cnt[COUNTER_WIDTH-1:0];
    accept = in_valid & in_ready;
    // A beat only touches the table when a list is open or being opened.
    active = accept & (in_first | ~in_idle);
    write  = active & ~match & ~full;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: list close wins, otherwise track saturation of the table
  always_comb begin
    state_d = state_q;
    if (active) begin
      if (in_last) begin
        state_d = StIdle;
      end else if (cnt_d == FullCnt) begin
        state_d = StSaturated;
      end else begin
        state_d = StCollect;
      end
    end
  end

  // FSM outputs and registered-output wiring
  always_comb begin
    in_idle    = (state_q == StIdle);
    in_ready   = ~out_valid_q | out_ready;
    out_valid  = out_valid_q;
    out_q      = out_q_q;
    out_llr    = out_llr_q;
    out_idx    = out_idx_q;
    list_done  = list_done_q;
    list_count = list_count_q;
    overflow   = overflow_q;
    frame_err  = frame_err_q;
  end

  // Table/counter next state
  always_comb begin
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (active) begin
      cnt_d = eff_cnt;
      vld_d = eff_vld;
      if (write) begin
        cnt_d         = eff_cnt + 1'b1;
        vld_d[wr_idx] = 1'b1;
      end
    end
  end

  // Output slot and status next state
  always_comb begin
    out_valid_d = out_valid_q;
    out_q_d     = out_q_q;
    out_llr_d   = out_llr_q;
    out_idx_d   = out_idx_q;
    if (write) begin
      // in_ready guarantees the slot is empty or draining this cycle
      out_valid_d = 1'b1;
      out_q_d     = in_q;
      out_llr_d   = in_llr;
      out_idx_d   = wr_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    overflow_d = overflow_q;
    if (accept & in_first) begin
      overflow_d = 1'b0;
    end
    if (active & ~match & full) begin
      overflow_d = 1'b1;
    end

    list_done_d  = active & in_last;
    list_count_d = (active & in_last) ? cnt_d : list_count_q;
    frame_err_d  = accept & ~in_first & in_idle;
  end

  // Table, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_q_q      <= '0;
      out_llr_q    <= '0;
      out_idx_q    <= '0;
      list_done_q  <= 1'b0;
      list_count_q <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_sym_q[i] <= '0;
      end
    end else begin
      vld_q        <= vld_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_q_q      <= out_q_d;
      out_llr_q    <= out_llr_d;
      out_idx_q    <= out_idx_d;
      list_done_q  <= list_done_d;
      list_count_q <= list_count_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      if (write) begin
        tbl_sym_q[wr_idx] <= in_q;
      end
    end
  end

endmodule

// File: tb/tb_nb_symbol_dedup_filter.sv
// Self-checking bench for nb_symbol_dedup_filter: directed list scenarios
// followed by randomized traffic, all compared against a queue-based model.
module tb_nb_symbol_dedup_filter;

  localparam int unsigned Depth = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_first;
  logic       in_last;
  logic [6:0] in_q;
  logic [5:0] in_llr;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_q;
  logic [5:0] out_llr;
  logic [3:0] out_idx;
  logic       list_done;
  logic [4:0] list_count;
  logic       overflow;
  logic       frame_err;

  nb_symbol_dedup_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_q      (in_q),
    .in_llr    (in_llr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_llr   (out_llr),
    .out_idx   (out_idx),
    .list_done (list_done),
    .list_count(list_count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  bit         m_ov;
  logic [6:0] m_q;
  logic [5:0] m_llr;
  logic [3:0] m_idx;
  bit         m_done;
  logic [4:0] m_count;
  bit         m_ovf;
  bit         m_ferr;
  bit         m_open;
  logic [6:0] seen[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_q", 32'(out_q), 32'(m_q));
      check("out_llr", 32'(out_llr), 32'(m_llr));
      check("out_idx", 32'(out_idx), 32'(m_idx));
    end
    check("list_done", 32'(list_done), 32'(m_done));
    check("list_count", 32'(list_count), 32'(m_count));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic model_reset();
    m_ov = 0; m_q = '0; m_llr = '0; m_idx = '0; m_done = 0; m_count = '0;
    m_ovf = 0; m_ferr = 0; m_open = 0;
    seen.delete();
  endtask

  // One accepted/offered beat applied to the list-level model.
  task automatic model_update(input bit acc, input bit f, input bit l, input logic [6:0] q,
                              input logic [5:0] llr, input bit rdy);
    bit found;
    m_done = 0;
    m_ferr = 0;
    if (m_ov && rdy) m_ov = 0;
    if (acc) begin
      if (f) begin
        seen.delete();
        m_open = 1;
        m_ovf  = 0;
      end
      if (!m_open) begin
        m_ferr = 1;
      end else begin
        found = 0;
        foreach (seen[i]) if (seen[i] == q) found = 1;
        if (!found) begin
          if (seen.size() < Depth) begin
            m_ov  = 1;
            m_q   = q;
            m_llr = llr;
            m_idx = 4'(seen.size());
            seen.push_back(q);
          end else begin
            m_ovf = 1;
          end
        end
        if (l) begin
          m_done  = 1;
          m_count = 5'(seen.size());
          m_open  = 0;
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic step(input bit v, input bit f, input bit l, input logic [6:0] q,
                      input logic [5:0] llr, input bit rdy);
    bit acc;
    in_valid  = v;
    in_first  = f;
    in_last   = l;
    in_q      = q;
    in_llr    = llr;
    out_ready = rdy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_ov || rdy));
    acc = v && (!m_ov || rdy);
    model_update(acc, f, l, q, llr, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input bit f, input bit l, input logic [6:0] q);
    step(1'b1, f, l, q, 6'($urandom_range(0, 63)), 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 1'b1);
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst_n    = 0;
    model_reset();
    #1;
    check_outputs();
    check("rst_out_q", 32'(out_q), 32'd0);
    check("rst_out_llr", 32'(out_llr), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit f, l, v, r;
    rst_n = 0; in_valid = 0; in_first = 0; in_last = 0;
    in_q = '0; in_llr = '0; out_ready = 1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Duplicates within one list
    send(1, 0, 7'd3); send(0, 0, 7'd5); send(0, 0, 7'd3); send(0, 0, 7'd7); send(0, 1, 7'd5);
    idle();
    check("t1_count", 32'(list_count), 32'd3);

    // Capacity overflow, then cleared by the next in_first
    for (int i = 0; i < 18; i++) send(i == 0, i == 17, 7'(i));
    idle();
    check("t2_count", 32'(list_count), 32'd16);
    check("t2_ovf", 32'(overflow), 32'd1);
    send(1, 1, 7'd1);
    check("t2_ovf_clr", 32'(overflow), 32'd0);

    // Downstream stall mid-list
    send(1, 0, 7'd10); send(0, 0, 7'd11);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 7'd12, 6'd33, 0);
    step(1, 0, 0, 7'd12, 6'd33, 1);
    send(0, 1, 7'd13);
    idle();

    // One-beat list, then a frameless beat
    send(1, 1, 7'd9);
    send(0, 0, 7'd20);
    idle();

    // Reset mid-list
    send(1, 0, 7'd30); send(0, 0, 7'd31); send(0, 0, 7'd32); send(0, 0, 7'd33);
    do_reset();
    send(1, 1, 7'd3);
    idle();

    // Back-to-back lists sharing a symbol
    send(1, 0, 7'd4); send(0, 1, 7'd6); send(1, 0, 7'd4); send(0, 1, 7'd8);
    idle();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        f = ($urandom_range(0, 24) == 0) || (!m_open && $urandom_range(0, 7) != 0);
        l = ($urandom_range(0, 13) == 0);
        r = ($urandom_range(0, 4) != 0);
        step(v, f, l, 7'($urandom_range(0, 23)), 6'($urandom_range(0, 63)), r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
